// File: rtl/array_ifm_skew.sv
// Skews ifm column vectors onto the systolic array's left edge: row h is delayed h+1 cycles.
// Define ARRAY_IFM_SKEW_ZERO_GATE_EN to force ifm[h] to zero whenever en_i[h] is low.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for the first beat of a tile (that beat carries clr)
// STREAM  | tile in progress, accepting further beats
// DRAIN   | last beat accepted; no intake until it has left row HEIGHT-1
module array_ifm_skew #(
   parameter int HEIGHT = 256,
   parameter int IWIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_last,
   input  logic signed [IWIDTH-1:0] in_ifm [HEIGHT-1:0],
   output logic [HEIGHT-1:0]        en_i,
   output logic [HEIGHT-1:0]        clr_i,
   output logic signed [IWIDTH-1:0] ifm [HEIGHT-1:0],
   output logic                     tile_done
);

   localparam int CW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(HEIGHT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STREAM,
      ST_DRAIN
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          accept;
   logic          first_beat;

   assign accept     = in_valid && in_ready;
   assign first_beat = (state_q == ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      in_ready  = 1'b0;
      tile_done = 1'b0;
      case (state_q)
         ST_IDLE, ST_STREAM: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (in_last) begin
                  state_d = ST_DRAIN;
                  cnt_d   = CNT_LOAD;
               end else begin
                  state_d = ST_STREAM;
               end
            end
         end
         ST_DRAIN: begin
            // Counter reaches zero the cycle the last beat sits in row HEIGHT-1
            if (cnt_q == '0) begin
               tile_done = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   for (genvar h = 0; h < HEIGHT; h++) begin : g_row
      logic [h:0]             en_q;
      logic [h:0]             clr_q;
      logic [h:0][IWIDTH-1:0] dat_q;
      logic [IWIDTH-1:0]      dat_in;

      // Stage 0 holds the previous beat across bubbles so stale data rides the diagonal
      assign dat_in = accept ? in_ifm[h] : dat_q[0];

      if (h == 0) begin : g_one
         always_ff @(posedge clk) begin
            if (rst) begin
               en_q  <= '0;
               clr_q <= '0;
               dat_q <= '0;
            end else begin
               en_q[0]  <= accept;
               clr_q[0] <= accept && first_beat;
               dat_q[0] <= dat_in;
            end
         end
      end else begin : g_many
         always_ff @(posedge clk) begin
            if (rst) begin
               en_q  <= '0;
               clr_q <= '0;
               dat_q <= '0;
            end else begin
               en_q  <= {en_q[h-1:0], accept};
               clr_q <= {clr_q[h-1:0], accept && first_beat};
               dat_q <= {dat_q[h-1:0], dat_in};
            end
         end
      end

      assign en_i[h]  = en_q[h];
      assign clr_i[h] = clr_q[h];
`ifdef ARRAY_IFM_SKEW_ZERO_GATE_EN
      assign ifm[h] = en_q[h] ? dat_q[h] : '0;
`else
      assign ifm[h] = dat_q[h];
`endif
   end

endmodule

// File: tb/tb_array_ifm_skew.sv
// Bench for array_ifm_skew (HEIGHT=4, IWIDTH=8): edge-indexed history model plus literal spot checks.
module tb_array_ifm_skew;
   localparam int H = 4;
   localparam int W = 8;
   localparam int N = 1024;

   logic clk = 1'b0;
   logic rst, in_valid, in_last, in_ready, tile_done;
   logic signed [W-1:0] in_ifm [H-1:0];
   logic [H-1:0]        en_i, clr_i;
   logic signed [W-1:0] ifm [H-1:0];

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   array_ifm_skew #(.HEIGHT(H), .IWIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_last(in_last), .in_ifm(in_ifm), .en_i(en_i), .clr_i(clr_i),
      .ifm(ifm), .tile_done(tile_done)
   );

   // Model: what was accepted at every edge, and where the current tile's last beat was taken.
   int  e = -1;
   int  rst_edge = -1;
   int  last_edge = -100;
   bit  in_tile = 1'b0;
   bit  acc_now;
   bit  acc_h [N];
   bit  clr_h [N];
   logic signed [W-1:0] dat_h [N][H];

   // Intake closes for H cycles starting with the one after the last beat's edge.
   function automatic bit exp_ready(int x);
      return !(x >= last_edge && x <= last_edge + H - 1);
   endfunction

   always @(posedge clk) begin
      e = e + 1;
      if (rst) begin
         rst_edge  = e;
         last_edge = -100;
         in_tile   = 1'b0;
         acc_h[e]  = 1'b0;
         clr_h[e]  = 1'b0;
         for (int h = 0; h < H; h++) dat_h[e][h] = '0;
      end else begin
         acc_now  = in_valid && exp_ready(e - 1);
         acc_h[e] = acc_now;
         clr_h[e] = acc_now && !in_tile;
         for (int h = 0; h < H; h++) dat_h[e][h] = acc_now ? in_ifm[h] : dat_h[e-1][h];
         if (acc_now) begin
            if (in_last) begin
               last_edge = e;
               in_tile   = 1'b0;
            end else begin
               in_tile = 1'b1;
            end
         end
      end
   end

   int  src;
   bit  x_en, x_clr, x_rdy, x_done;
   logic signed [W-1:0] x_dat;

   always @(negedge clk) begin
      if (e >= 0) begin
         vectors++;
         for (int h = 0; h < H; h++) begin
            src = e - h;
            if (src <= rst_edge) begin
               x_en = 1'b0; x_clr = 1'b0; x_dat = '0;
            end else begin
               x_en = acc_h[src]; x_clr = clr_h[src]; x_dat = dat_h[src][h];
            end
`ifdef ARRAY_IFM_SKEW_ZERO_GATE_EN
            if (!x_en) x_dat = '0;
`endif
            if (en_i[h] !== x_en) begin
               miscompares++;
               $display("FAIL en_i[%0d] cycle %0d: got %b want %b", h, e, en_i[h], x_en);
            end
            if (clr_i[h] !== x_clr) begin
               miscompares++;
               $display("FAIL clr_i[%0d] cycle %0d: got %b want %b", h, e, clr_i[h], x_clr);
            end
            if (ifm[h] !== x_dat) begin
               miscompares++;
               $display("FAIL ifm[%0d] cycle %0d: got %0d want %0d", h, e, ifm[h], x_dat);
            end
         end
         x_rdy  = exp_ready(e);
         x_done = (e == last_edge + H - 1);
         if (in_ready !== x_rdy) begin
            miscompares++;
            $display("FAIL in_ready cycle %0d: got %b want %b", e, in_ready, x_rdy);
         end
         if (tile_done !== x_done) begin
            miscompares++;
            $display("FAIL tile_done cycle %0d: got %b want %b", e, tile_done, x_done);
         end
      end
   end

   task automatic chk(input string name, input int got, input int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_beat(input int a, input int b, input int c, input int d);
      in_ifm[0] = W'(a);
      in_ifm[1] = W'(b);
      in_ifm[2] = W'(c);
      in_ifm[3] = W'(d);
   endtask

   int exp_bubble;

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
      set_beat(0, 0, 0, 0);
      step(); step();
      chk("reset en_i", int'(en_i), 0);
      chk("reset clr_i", int'(clr_i), 0);
      for (int h = 0; h < H; h++) chk("reset ifm", int'(ifm[h]), 0);
      chk("reset tile_done", int'(tile_done), 0);
      chk("reset in_ready", int'(in_ready), 1);
      rst = 1'b0;

      // Three-beat tile
      set_beat(1, 2, 3, 4); in_valid = 1'b1; in_last = 1'b0; step();
      set_beat(5, 6, 7, 8); step();
      set_beat(9, 10, 11, 12); in_last = 1'b1; step();
      in_valid = 1'b0; in_last = 1'b0;
      chk("t3 en_i diag", int'(en_i), 7);
      chk("t3 clr_i diag", int'(clr_i), 4);
      chk("t3 ifm[1]", int'(ifm[1]), 6);
      chk("t3 ifm[2]", int'(ifm[2]), 3);
      chk("t3 in_ready drain", int'(in_ready), 0);
      step(); step(); step();
      chk("t3 tile_done", int'(tile_done), 1);
      chk("t3 en_i last", int'(en_i), 8);
      chk("t3 ifm[3] last", int'(ifm[3]), 12);
      step();
      chk("t3 ready back", int'(in_ready), 1);
      chk("t3 done gone", int'(tile_done), 0);

      // Single-beat tile
      set_beat(-1, -2, -3, -4); in_valid = 1'b1; in_last = 1'b1; step();
      in_valid = 1'b0; in_last = 1'b0;
      chk("t1 en_i", int'(en_i), 1);
      chk("t1 clr_i", int'(clr_i), 1);
      chk("t1 ifm[0]", int'(ifm[0]), -1);
      step(); step(); step();
      chk("t1 tile_done", int'(tile_done), 1);
      chk("t1 clr_i row3", int'(clr_i), 8);
      chk("t1 ifm[3]", int'(ifm[3]), -4);
      step();

      // Beat, gap, last beat; then a held beat while intake is closed
      set_beat(10, 11, 12, 13); in_valid = 1'b1; in_last = 1'b0; step();
      in_valid = 1'b0; step();
      set_beat(20, 21, 22, 23); in_valid = 1'b1; in_last = 1'b1; step();
      set_beat(30, 31, 32, 33);
      chk("gap en_i", int'(en_i), 5);
      chk("gap clr_i", int'(clr_i), 4);
      chk("gap ifm[0]", int'(ifm[0]), 20);
      chk("gap ifm[2]", int'(ifm[2]), 12);
      step(); step(); step();
      chk("gap tile_done", int'(tile_done), 1);
      chk("gap clr_i late", int'(clr_i), 0);
      step();
      chk("held en_i", int'(en_i), 0);
      step();
      in_valid = 1'b0; in_last = 1'b0;
      chk("held accepted en", int'(en_i), 1);
      chk("held accepted clr", int'(clr_i), 1);
      chk("held ifm[0]", int'(ifm[0]), 30);
      step(); step(); step();
      chk("held tile_done", int'(tile_done), 1);
      step();

      // Reset one cycle into DRAIN
      set_beat(40, 41, 42, 43); in_valid = 1'b1; in_last = 1'b1; step();
      in_valid = 1'b0; in_last = 1'b0; rst = 1'b1; step();
      rst = 1'b0;
      chk("abort en_i", int'(en_i), 0);
      chk("abort in_ready", int'(in_ready), 1);
      chk("abort ifm[0]", int'(ifm[0]), 0);
      for (int i = 0; i < 4; i++) begin
         chk("abort no done", int'(tile_done), 0);
         step();
      end

      // Bubble after a beat of sevens
      set_beat(7, 7, 7, 7); in_valid = 1'b1; in_last = 1'b0; step();
      in_valid = 1'b0; step();
      exp_bubble = 7;
`ifdef ARRAY_IFM_SKEW_ZERO_GATE_EN
      exp_bubble = 0;
`endif
      chk("bubble en_i", int'(en_i), 2);
      chk("bubble ifm[0]", int'(ifm[0]), exp_bubble);
      chk("bubble ifm[1]", int'(ifm[1]), 7);
      set_beat(1, 1, 1, 1); in_valid = 1'b1; in_last = 1'b1; step();
      in_valid = 1'b0; in_last = 1'b0;
      for (int i = 0; i < 5; i++) step();

      // Longer tile with periodic gaps
      for (int i = 0; i < 10; i++) begin
         in_valid = (i % 3 != 1);
         in_last  = (i == 9);
         set_beat(i * 4 - 20, i * 4 - 19, i * 4 - 18, i * 4 - 17);
         step();
      end
      in_valid = 1'b0; in_last = 1'b0;
      for (int i = 0; i < 6; i++) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/array_ifm_skew.md
ARRAY_IFM_SKEW -- requirements
Module: array_ifm_skew

Interface
REQ-001 SHALL have parameter HEIGHT, default 256; number of array rows fed.
REQ-002 SHALL have parameter IWIDTH, default 8; signed ifm element width.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream presents an ifm column vector.
REQ-007 in_ready  output  1  block accepts the vector this cycle.
REQ-008 in_last  input  1  qualifies the vector as the final beat of a tile.
REQ-009 in_ifm  input  HEIGHT x IWIDTH signed (unpacked [HEIGHT-1:0])  one element per row.
REQ-010 en_i  output  HEIGHT  per-row enable into the array's left edge.
REQ-011 clr_i  output  HEIGHT  per-row clear, marks the first beat of a tile.
REQ-012 ifm  output  HEIGHT x IWIDTH signed (unpacked [HEIGHT-1:0])  skewed row data.
REQ-013 tile_done  output  1  one-cycle pulse when the last beat leaves row HEIGHT-1.

Function
REQ-014 A beat SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-015 Element h of a beat accepted at edge t SHALL appear on ifm[h] with en_i[h]=1 in the cycle after edge t+h (latency h+1 edges, row 0 registered once).
REQ-016 Each row SHALL use an h+1-deep register delay line carrying {en, clr, data}; rows never stall.
REQ-017 Cycles with no accepted beat SHALL propagate as en_i=0 and clr_i=0 bubbles along the same diagonal.
REQ-018 FSM states: IDLE, STREAM, DRAIN.
REQ-019 IDLE: in_ready=1; accepted beat with in_last=0 goes to STREAM; with in_last=1 goes to DRAIN.
REQ-020 STREAM: in_ready=1; accepted beat with in_last=1 goes to DRAIN; otherwise stay.
REQ-021 The first beat accepted from IDLE SHALL carry clr=1; all other beats carry clr=0; a single-beat tile carries clr=1 and is also last.
REQ-022 On entry to DRAIN a counter SHALL load HEIGHT-1 and decrement each cycle; in_ready=0 throughout DRAIN.
REQ-023 tile_done SHALL be 1 exactly when state=DRAIN and counter=0, coinciding with en_i[HEIGHT-1] for the last beat; next state IDLE.
REQ-024 For HEIGHT=1, DRAIN SHALL last one cycle with tile_done asserted in it.
REQ-025 in_valid while in_ready=0 SHALL be ignored; upstream holds the vector.
REQ-026 No arithmetic on data; widths pass through unchanged.

Reset
REQ-027 rst SHALL clear every delay-line stage, state to IDLE, counter to 0.
REQ-028 After reset: en_i=0, clr_i=0, ifm=0, tile_done=0, in_ready=1.
REQ-029 Reset mid-STREAM or mid-DRAIN SHALL discard all in-flight beats; no tile_done for the aborted tile.

Configuration
REQ-030 Macro ARRAY_IFM_SKEW_ZERO_GATE_EN: when defined, ifm[h] SHALL be driven 0 whenever en_i[h]=0.
REQ-031 Without the macro, ifm[h] SHALL show the raw delay-line data (stale value of the previous beat during bubbles).

Verification (HEIGHT=4, IWIDTH=8)
REQ-032 Reset held 2 cycles -> en_i=0000, clr_i=0000, ifm all 0, tile_done=0, in_ready=1.
REQ-033 Beats {1,2,3,4},{5,6,7,8},{9,10,11,12} at edges t..t+2, last on third -> row h en_i=1 for cycles after t+h..t+h+2 with values (4k+h+1), clr_i[h]=1 only for first, in_ready=0 for 4 cycles, tile_done in cycle after t+5.
REQ-034 Single beat {-1,-2,-3,-4} with in_last=1 -> each row shows clr_i=en_i=1 once on the diagonal, tile_done in cycle after t+3.
REQ-035 Beat, one-cycle in_valid gap, beat -> en_i[h] pattern 1,0,1 shifted h cycles per row; clr_i only on first beat.
REQ-036 rst asserted one cycle into DRAIN -> next cycle en_i=0000, in_ready=1, tile_done never pulses.
REQ-037 Bubble after beat {7,7,7,7}: with ARRAY_IFM_SKEW_ZERO_GATE_EN ifm[h]=0 in the bubble; without it ifm[h]=7.
